// File: rtl/render_pkg.sv
// Shared VGA widths and scheduler state encoding for the sprite render path.
package render_pkg;
    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int COL_W = 3;

    localparam logic [COL_W-1:0] COLOUR_BLACK = 3'b000;

    // Drawers need a few cycles to load coordinates before their pixels are valid.
    localparam int PLOT_START = 4;

    typedef enum logic [2:0] {
        ST_WAIT_TICK,
        ST_ERASE,
        ST_GAP_E,
        ST_GAP_D,
        ST_DRAW,
        ST_DONE
    } state_t;
endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider; tick is high for the last cycle of each frame period.
module frame_tick_gen #(
    parameter int FRAME_DIV = 833333
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign tick = (count == LAST);
endmodule

// File: rtl/sprite_render_scheduler.sv
// Per-frame erase-then-draw sequencer for the sprite drawers, with the
// selected drawer's pixel stream registered onto the single VGA write port.
module sprite_render_scheduler
    import render_pkg::*;
#(
    parameter int NUM_SPRITES  = 4,
    parameter int FRAME_DIV    = 833333,
    parameter int ERASE_CYCLES = 44,
    parameter int DRAW_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [X_W*NUM_SPRITES-1:0]   sprite_x,
    input  logic [Y_W*NUM_SPRITES-1:0]   sprite_y,
    input  logic [COL_W*NUM_SPRITES-1:0] sprite_colour,
    input  logic [NUM_SPRITES-1:0]       sprite_done,
    output logic [NUM_SPRITES-1:0]       draw_en,
    output logic [NUM_SPRITES-1:0]       erase_en,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COL_W-1:0]             vga_colour,
    output logic                         vga_plot,
    output logic                         frame_overrun,
    output logic                         timeout_err,
    output logic                         busy
);
    localparam int CNT_MAX = (ERASE_CYCLES > DRAW_TIMEOUT) ? ERASE_CYCLES : DRAW_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SEL_W   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAW_LAST  = CNT_W'(DRAW_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PLOT_FROM  = CNT_W'(PLOT_START);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_SPRITES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] sel;
    logic             first_frame;
    logic             pending;
    logic             tick;

    logic [X_W-1:0]   mux_x;
    logic [Y_W-1:0]   mux_y;
    logic [COL_W-1:0] mux_colour;
    logic             mux_done;

    frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        mux_x      = sprite_x[int'(sel)*X_W +: X_W];
        mux_y      = sprite_y[int'(sel)*Y_W +: Y_W];
        mux_colour = sprite_colour[int'(sel)*COL_W +: COL_W];
        mux_done   = sprite_done[sel];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_WAIT_TICK;
            cnt           <= '0;
            sel           <= '0;
            first_frame   <= 1'b1;
            pending       <= 1'b0;
            timeout_err   <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            // Only one tick is ever queued; a second one while queued is reported and dropped.
            frame_overrun <= tick && pending;
            if (state == ST_WAIT_TICK)
                pending <= 1'b0;
            else if (tick)
                pending <= 1'b1;

            cnt <= cnt + CNT_W'(1);
            case (state)
                ST_WAIT_TICK: if (tick || pending) begin
                    sel   <= '0;
                    cnt   <= '0;
                    state <= first_frame ? ST_DRAW : ST_ERASE;
                end
                ST_ERASE: if (cnt == ERASE_LAST) begin
                    if (sel == SEL_LAST) begin
                        sel   <= '0;
                        state <= ST_GAP_D;
                    end else begin
                        sel   <= sel + SEL_W'(1);
                        state <= ST_GAP_E;
                    end
                end
                ST_GAP_E: begin
                    cnt   <= '0;
                    state <= ST_ERASE;
                end
                ST_GAP_D: begin
                    cnt   <= '0;
                    state <= ST_DRAW;
                end
                ST_DRAW: if (mux_done || cnt == DRAW_LAST) begin
                    if (!mux_done)
                        timeout_err <= 1'b1;
                    if (sel == SEL_LAST)
                        state <= ST_DONE;
                    else begin
                        sel   <= sel + SEL_W'(1);
                        state <= ST_GAP_D;
                    end
                end
                ST_DONE: begin
                    first_frame <= 1'b0;
                    state       <= ST_WAIT_TICK;
                end
                default: state <= ST_WAIT_TICK;
            endcase
        end
    end

    always_comb begin
        draw_en  = '0;
        erase_en = '0;
        if (state == ST_DRAW)
            draw_en[sel] = 1'b1;
        if (state == ST_ERASE)
            erase_en[sel] = 1'b1;
    end

    assign busy = (state != ST_WAIT_TICK);

    // One cycle of latency lines the mux up with the drawers' registered coordinates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= 1'b0;
            if (state == ST_ERASE) begin
                vga_x      <= mux_x;
                vga_y      <= mux_y;
                vga_colour <= COLOUR_BLACK;
                vga_plot   <= (cnt >= PLOT_FROM);
            end else if (state == ST_DRAW) begin
                vga_x      <= mux_x;
                vga_y      <= mux_y;
                vga_colour <= mux_colour;
                vga_plot   <= (cnt >= PLOT_FROM) && !mux_done;
            end
        end
    end
endmodule

// File: tb/tb_sprite_render_scheduler.sv
// Directed bench: a fast-done instance (FRAME_DIV=200) and an always-timing-out
// instance (FRAME_DIV=50) checked against hand-computed cycle tables.
module tb_sprite_render_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] sprite_x;
    logic [15:0] sprite_y;
    logic [5:0]  sprite_colour;
    logic [1:0]  done_a;
    logic [1:0]  done_b;
    logic [1:0]  hold_low;

    logic [1:0] draw_a, erase_a, draw_b, erase_b;
    logic [8:0] x_a, x_b;
    logic [7:0] y_a, y_b;
    logic [2:0] c_a, c_b;
    logic       pl_a, pl_b, ov_a, ov_b, te_a, te_b, bz_a, bz_b;

    int cyc = 0;
    int nvec = 0;
    int nmis = 0;
    int dcnt [2];
    bit onehot_bad = 1'b0;

    always #5 clk = ~clk;

    sprite_render_scheduler #(.NUM_SPRITES(2), .FRAME_DIV(200), .ERASE_CYCLES(44), .DRAW_TIMEOUT(255)) u_dut (
        .clk(clk), .reset(reset), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_colour(sprite_colour), .sprite_done(done_a), .draw_en(draw_a), .erase_en(erase_a),
        .vga_x(x_a), .vga_y(y_a), .vga_colour(c_a), .vga_plot(pl_a),
        .frame_overrun(ov_a), .timeout_err(te_a), .busy(bz_a));

    sprite_render_scheduler #(.NUM_SPRITES(2), .FRAME_DIV(50), .ERASE_CYCLES(44), .DRAW_TIMEOUT(255)) u_slow (
        .clk(clk), .reset(reset), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_colour(sprite_colour), .sprite_done(done_b), .draw_en(draw_b), .erase_en(erase_b),
        .vga_x(x_b), .vga_y(y_b), .vga_colour(c_b), .vga_plot(pl_b),
        .frame_overrun(ov_b), .timeout_err(te_b), .busy(bz_b));

    always @(posedge clk) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Drawer model: done rises 44 cycles after draw_en rises, holds until erased.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset || erase_a[i]) begin
                dcnt[i]   <= 0;
                done_a[i] <= 1'b0;
            end else if (draw_a[i] && !done_a[i]) begin
                dcnt[i] <= dcnt[i] + 1;
                if (dcnt[i] >= 43 && !hold_low[i]) done_a[i] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset && ($countones(draw_a | erase_a) > 1 || $countones(draw_b | erase_b) > 1))
            onehot_bad = 1'b1;
    end

    typedef struct {
        int         cyc;
        bit         w;
        logic [1:0] er, dr;
        logic       pl, bz, ov, te;
        bit         cp;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        int         act;
    } vec_t;

    vec_t vt[$];

    function automatic void add(int cyc_i, bit w, logic [1:0] er, logic [1:0] dr,
                                logic pl, logic bz, logic ov, logic te, int act);
        vec_t v;
        v.cyc = cyc_i; v.w = w; v.er = er; v.dr = dr; v.pl = pl; v.bz = bz;
        v.ov = ov; v.te = te; v.cp = 1'b0; v.x = '0; v.y = '0; v.c = '0; v.act = act;
        vt.push_back(v);
    endfunction

    function automatic void addp(int cyc_i, logic [1:0] er, logic [1:0] dr,
                                 logic [8:0] x, logic [7:0] y, logic [2:0] c);
        vec_t v;
        v.cyc = cyc_i; v.w = 1'b0; v.er = er; v.dr = dr; v.pl = 1'b1; v.bz = 1'b1;
        v.ov = 1'b0; v.te = 1'b0; v.cp = 1'b1; v.x = x; v.y = y; v.c = c; v.act = 0;
        vt.push_back(v);
    endfunction

    task automatic check_vec(input vec_t v);
        logic [7:0]  got, exp;
        logic [19:0] gp, ep;
        got = v.w ? {erase_b, draw_b, pl_b, bz_b, ov_b, te_b} : {erase_a, draw_a, pl_a, bz_a, ov_a, te_a};
        exp = {v.er, v.dr, v.pl, v.bz, v.ov, v.te};
        gp  = {x_a, y_a, c_a};
        ep  = {v.x, v.y, v.c};
        nvec++;
        if (got !== exp || (v.cp && gp !== ep)) begin
            nmis++;
            $display("FAIL vec cyc%0d dut%0d: er_dr_pl_bz_ov_te got %b want %b; xyc got %h want %h",
                     v.cyc, v.w, got, exp, gp, v.cp ? ep : gp);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        hold_low = 2'b00;
        done_b = 2'b00;
        sprite_x = {9'd100, 9'd37};
        sprite_y = {8'd20, 8'd11};
        sprite_colour = {3'b101, 3'b110};

        // cyc, dut, erase, draw, plot, busy, overrun, timeout, action
        add(49, 1, 0, 0, 0, 0, 0, 0, 0);
        add(50, 1, 0, 1, 0, 1, 0, 0, 0);
        add(100, 1, 0, 1, 1, 1, 0, 0, 0);
        add(149, 1, 0, 1, 1, 1, 0, 0, 0);
        add(150, 1, 0, 1, 1, 1, 1, 0, 0);
        add(151, 1, 0, 1, 1, 1, 0, 0, 0);
        add(199, 0, 0, 0, 0, 0, 0, 0, 0);
        add(200, 0, 0, 1, 0, 1, 0, 0, 0);
        add(244, 0, 0, 1, 1, 1, 0, 0, 0);
        add(245, 0, 0, 0, 0, 1, 0, 0, 0);
        add(246, 0, 0, 2, 0, 1, 0, 0, 0);
        add(250, 0, 0, 2, 0, 1, 0, 0, 0);
        addp(251, 0, 2, 9'd100, 8'd20, 3'b101);
        add(290, 0, 0, 2, 1, 1, 0, 0, 0);
        add(291, 0, 0, 0, 0, 1, 0, 0, 0);
        add(292, 0, 0, 0, 0, 0, 0, 0, 0);
        add(305, 1, 0, 0, 1, 1, 0, 1, 0);
        add(306, 1, 0, 2, 0, 1, 0, 1, 0);
        add(399, 0, 0, 0, 0, 0, 0, 0, 0);
        add(400, 0, 1, 0, 0, 1, 0, 0, 0);
        add(404, 0, 1, 0, 0, 1, 0, 0, 0);
        addp(405, 1, 0, 9'd37, 8'd11, 3'b000);
        add(443, 0, 1, 0, 1, 1, 0, 0, 0);
        add(444, 0, 0, 0, 1, 1, 0, 0, 0);
        add(445, 0, 2, 0, 0, 1, 0, 0, 0);
        addp(450, 2, 0, 9'd100, 8'd20, 3'b000);
        add(488, 0, 2, 0, 1, 1, 0, 0, 0);
        add(489, 0, 0, 0, 1, 1, 0, 0, 0);
        add(490, 0, 0, 1, 0, 1, 0, 0, 0);
        addp(495, 0, 1, 9'd37, 8'd11, 3'b110);
        add(534, 0, 0, 1, 1, 1, 0, 0, 0);
        add(535, 0, 0, 0, 0, 1, 0, 0, 0);
        add(536, 0, 0, 2, 0, 1, 0, 0, 0);
        add(561, 1, 0, 0, 1, 1, 0, 1, 0);
        add(562, 1, 0, 0, 0, 0, 0, 1, 0);
        add(563, 1, 1, 0, 0, 1, 0, 1, 0);
        add(580, 0, 0, 2, 1, 1, 0, 0, 0);
        add(581, 0, 0, 0, 0, 1, 0, 0, 0);
        add(582, 0, 0, 0, 0, 0, 0, 0, 0);
        add(590, 0, 0, 0, 0, 0, 0, 0, 1);
        add(600, 0, 1, 0, 0, 1, 0, 0, 0);
        add(736, 0, 0, 2, 0, 1, 0, 0, 0);
        add(990, 0, 0, 2, 1, 1, 0, 0, 0);
        add(991, 0, 0, 0, 1, 1, 0, 1, 0);
        add(992, 0, 0, 0, 0, 0, 0, 1, 2);
        add(993, 0, 1, 0, 0, 1, 0, 1, 0);
        add(1100, 0, 0, 1, 1, 1, 0, 1, 0);

        repeat (3) @(negedge clk);
        chk("reset_draw", {30'd0, draw_a}, 32'd0);
        chk("reset_busy", {31'd0, bz_a}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            wait_cyc(vt[i].cyc);
            check_vec(vt[i]);
            if (vt[i].act == 1) hold_low = 2'b10;
            if (vt[i].act == 2) hold_low = 2'b00;
        end

        // Reset sampled mid-draw (cycle 1100): everything clears on the next cycle.
        reset = 1'b0;
        @(negedge clk);
        chk("rst_enables", {28'd0, draw_a, erase_a}, 32'd0);
        chk("rst_plot_busy", {30'd0, pl_a, bz_a}, 32'd0);
        chk("rst_timeout", {30'd0, te_a, te_b}, 32'd0);
        chk("rst_pixels", {12'd0, x_a, y_a, c_a}, 32'd0);
        chk("rst_slow_busy", {30'd0, bz_b, draw_b[0]}, 32'd0);
        reset = 1'b1;

        wait_cyc(50);
        chk("post_slow_draw", {28'd0, erase_b, draw_b}, 32'h1);
        wait_cyc(199);
        chk("post_idle", {29'd0, bz_a, draw_a}, 32'd0);
        wait_cyc(200);
        chk("post_first_frame", {28'd0, erase_a, draw_a}, 32'h1);
        chk("onehot_enables", {31'd0, onehot_bad}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
